// File: rtl/computer_mc.sv
// computer_mc: multi-cycle register computer with FETCH/EXEC/MEM/HALTED sequencing.
// Instruction and data memories are external, behind req/ack handshakes, so
// wait-stated memories are supported.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_req/addr/ack/rdata       instruction fetch handshake (addr = PC)
//   dmem_req/we/addr/wdata/ack/rdata  data access handshake
//   pc_out                        current PC
//   alu_out                       last ALU result (ops 3..9)
//   status                        {Z,N,C,V}
//   halted                        core stopped until reset
module computer_mc #(
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 8,
  parameter int unsigned NREG = 4,
  localparam int unsigned RW  = $clog2(NREG),
  localparam int unsigned IW  = 4 + 2 * RW + DW
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic [AW-1:0] pc_out,
  output logic [DW-1:0] alu_out,
  output logic [3:0]    status,
  output logic          halted
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOVK = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_ADDK = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_LDR  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_JZ   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALTED} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ir;
  logic [AW-1:0]   pc;
  logic [DW-1:0]   rf [NREG];

  logic [3:0]      op;
  logic [RW-1:0]   rd, rs;
  logic [DW-1:0]   k;
  logic [DW-1:0]   rd_val, rs_val;
  logic [DW-1:0]   op_b, alu_res;
  logic [DW:0]     sum;
  logic            alu_c, alu_v, alu_upd;

  // Instruction field decode
  assign op     = ir[IW-1 -: 4];
  assign rd     = ir[IW-5 -: RW];
  assign rs     = ir[IW-5-RW -: RW];
  assign k      = ir[DW-1:0];
  assign rd_val = rf[rd];
  assign rs_val = rf[rs];

  assign imem_addr = pc;
  assign pc_out    = pc;

  // ALU: result and flags for ops 3..9
  always_comb begin
    op_b    = (op == OP_ADDK) ? k : rs_val;
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_upd = 1'b1;
    case (op)
      OP_ADD, OP_ADDK: begin
        sum     = {1'b0, rd_val} + {1'b0, op_b};
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
        alu_v   = (rd_val[DW-1] == op_b[DW-1]) && (alu_res[DW-1] != rd_val[DW-1]);
      end
      OP_SUB: begin
        alu_res = rd_val - op_b;
        alu_c   = rd_val < op_b;
        alu_v   = (rd_val[DW-1] != op_b[DW-1]) && (alu_res[DW-1] != rd_val[DW-1]);
      end
      OP_AND:  alu_res = rd_val & op_b;
      OP_OR:   alu_res = rd_val | op_b;
      OP_XOR:  alu_res = rd_val ^ op_b;
      OP_SHL: begin
        alu_res = rd_val << 1;
        alu_c   = rd_val[DW-1];
      end
      default: alu_upd = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (imem_ack) state_nxt = S_EXEC;
      S_EXEC: begin
        if (op == OP_LD || op == OP_ST || op == OP_LDR) state_nxt = S_MEM;
        else if (op == OP_HALT)                         state_nxt = S_HALTED;
        else                                            state_nxt = S_FETCH;
      end
      S_MEM:    if (dmem_ack) state_nxt = S_FETCH;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Output decode; requests are suppressed during reset
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH:  imem_req = !rst;
      S_MEM:    dmem_req = !rst;
      S_HALTED: halted   = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: IR, PC, register file, flags and data-bus latches
  always_ff @(posedge clk) begin
    if (rst) begin
      ir         <= '0;
      pc         <= '0;
      alu_out    <= '0;
      status     <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (imem_ack) ir <= imem_rdata;
        S_EXEC: begin
          if (alu_upd) begin
            rf[rd]  <= alu_res;
            alu_out <= alu_res;
            status  <= {alu_res == '0, alu_res[DW-1], alu_c, alu_v};
            pc      <= pc + AW'(1);
          end else begin
            case (op)
              OP_NOP:  pc <= pc + AW'(1);
              OP_MOVK: begin rf[rd] <= k;      pc <= pc + AW'(1); end
              OP_MOV:  begin rf[rd] <= rs_val; pc <= pc + AW'(1); end
              OP_LD: begin
                dmem_we   <= 1'b0;
                dmem_addr <= AW'(k);
              end
              OP_ST: begin
                dmem_we    <= 1'b1;
                dmem_addr  <= AW'(k);
                dmem_wdata <= rd_val;
              end
              OP_LDR: begin
                dmem_we   <= 1'b0;
                dmem_addr <= AW'(rs_val);
              end
              OP_JMP:  pc <= AW'(k);
              OP_JZ:   pc <= status[3] ? AW'(k) : pc + AW'(1);
              default: ;
            endcase
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (!dmem_we) rf[rd] <= dmem_rdata;
            pc <= pc + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
